// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the detector stimulus sequencer: FSM state encoding
// and the default pacing between issued bits.
package seq_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_ISSUE = 3'd2,
      ST_GAP   = 3'd3,
      ST_DONE  = 3'd4,
      ST_ABRT  = 3'd5
   } state_e;

   localparam int GAP_CYCLES_DEF = 4;

endpackage

// File: rtl/seq_stim_ctrl_if.sv
// Host/detector-facing bundle of the stimulus sequencer. The master side is the
// VIO/host plus the detector output; the slave side is the sequencer itself.
interface seq_stim_ctrl_if #(
   parameter int PAT_W = 16,
   parameter int LEN_W = 5,
   parameter int CNT_W = 5
);
   logic             load;
   logic [PAT_W-1:0] pattern_in;
   logic [LEN_W-1:0] len_in;
   logic             start;
   logic             abort;
   logic             det_out;
   logic             det_clear;
   logic             input_0;
   logic             input_1;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] match_count;
   logic [PAT_W-1:0] match_map;

   modport master (
      output load, pattern_in, len_in, start, abort, det_out,
      input  det_clear, input_0, input_1, busy, done, match_count, match_map
   );

   modport slave (
      input  load, pattern_in, len_in, start, abort, det_out,
      output det_clear, input_0, input_1, busy, done, match_count, match_map
   );
endinterface

// File: rtl/gap_timer.sv
// Loadable 8-bit down-counter pacing the idle cycles between issued bits;
// expire is high during the last counted cycle.
module gap_timer (
   input  logic       clk,
   input  logic       clear_n,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic       expire
);

   logic [7:0] count_r;

   // Count register: reload on request, otherwise count down to zero and stop.
   always_ff @(posedge clk) begin
      if (!clear_n) begin
         count_r <= 8'd0;
      end else if (load) begin
         count_r <= load_val;
      end else if (count_r != 8'd0) begin
         count_r <= count_r - 8'd1;
      end else begin
         count_r <= count_r;
      end
   end

   assign expire = (count_r == 8'd1);

endmodule

// File: rtl/seq_stim_ctrl.sv
// Replays a stored bit pattern into the sequence detector as paced one-cycle
// pulses and records which issued bits the detector flagged.
module seq_stim_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int PAT_W      = 16,
   parameter int LEN_W      = 5,
   parameter int GAP_CYCLES = GAP_CYCLES_DEF,
   parameter int CNT_W      = 5
) (
   input logic            clk_100M,
   input logic            clear_n,
   seq_stim_ctrl_if.slave bus
);

   state_e           state_r;
   state_e           state_nxt_s;
   logic [PAT_W-1:0] pat_r;
   logic [LEN_W-1:0] len_r;
   logic [LEN_W-1:0] idx_r;
   logic [LEN_W-1:0] idx_nxt_s;
   logic [LEN_W-1:0] idx_inc_s;
   logic [LEN_W-1:0] len_clamp_s;
   logic [PAT_W-1:0] nxt_onehot_s;
   logic [PAT_W-1:0] cur_onehot_s;
   logic             gap_load_s;
   logic             gap_expire_s;

   logic             det_clear_s, input_0_s, input_1_s, busy_s, done_s;
   logic             det_clear_r, input_0_r, input_1_r, busy_r, done_r;
   logic [CNT_W-1:0] match_count_r;
   logic [PAT_W-1:0] match_map_r;

   assign idx_inc_s    = idx_r + LEN_W'(1);
   assign cur_onehot_s = PAT_W'(1) << idx_r;
   assign nxt_onehot_s = PAT_W'(1) << idx_nxt_s;
   assign len_clamp_s  = (bus.len_in > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.len_in;
   assign gap_load_s   = (state_r == ST_ISSUE);

   gap_timer u_gap_timer (
      .clk      (clk_100M),
      .clear_n  (clear_n),
      .load     (gap_load_s),
      .load_val (8'(GAP_CYCLES)),
      .expire   (gap_expire_s)
   );

   // State and bit-index registers.
   always_ff @(posedge clk_100M) begin
      if (!clear_n) begin
         state_r <= ST_IDLE;
         idx_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         idx_r   <= idx_nxt_s;
      end
   end

   // Next-state logic; abort wins over normal progress in every busy state but DONE.
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) state_nxt_s = ST_CLR;
            else           state_nxt_s = ST_IDLE;
         end
         ST_CLR: begin
            idx_nxt_s = '0;
            if (bus.abort)               state_nxt_s = ST_ABRT;
            else if (len_r != LEN_W'(0)) state_nxt_s = ST_ISSUE;
            else                         state_nxt_s = ST_DONE;
         end
         ST_ISSUE: begin
            if (bus.abort) state_nxt_s = ST_ABRT;
            else           state_nxt_s = ST_GAP;
         end
         ST_GAP: begin
            if (bus.abort) begin
               state_nxt_s = ST_ABRT;
            end else if (gap_expire_s) begin
               idx_nxt_s = idx_inc_s;
               if (idx_inc_s == len_r) state_nxt_s = ST_DONE;
               else                    state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_GAP;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         ST_ABRT: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode from the upcoming state so the output flops line up with state_r.
   always_comb begin
      det_clear_s = (state_nxt_s == ST_CLR) || (state_nxt_s == ST_ABRT);
      busy_s      = (state_nxt_s != ST_IDLE);
      done_s      = (state_nxt_s == ST_DONE);
      if (state_nxt_s == ST_ISSUE) begin
         input_1_s = |(pat_r & nxt_onehot_s);
         input_0_s = ~(|(pat_r & nxt_onehot_s));
      end else begin
         input_1_s = 1'b0;
         input_0_s = 1'b0;
      end
   end

   // Output registers.
   always_ff @(posedge clk_100M) begin
      if (!clear_n) begin
         det_clear_r <= 1'b0;
         input_0_r   <= 1'b0;
         input_1_r   <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         det_clear_r <= det_clear_s;
         input_0_r   <= input_0_s;
         input_1_r   <= input_1_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
      end
   end

   // Pattern store: only written while idle, so a run always sees a stable pattern.
   always_ff @(posedge clk_100M) begin
      if (!clear_n) begin
         pat_r <= '0;
         len_r <= '0;
      end else if ((state_r == ST_IDLE) && bus.load) begin
         pat_r <= bus.pattern_in;
         len_r <= len_clamp_s;
      end else begin
         pat_r <= pat_r;
         len_r <= len_r;
      end
   end

   // Match recording: cleared at run start, sampled only in the issue cycle.
   always_ff @(posedge clk_100M) begin
      if (!clear_n) begin
         match_count_r <= '0;
         match_map_r   <= '0;
      end else if (state_r == ST_CLR) begin
         match_count_r <= '0;
         match_map_r   <= '0;
      end else if ((state_r == ST_ISSUE) && bus.det_out) begin
         match_map_r <= match_map_r | cur_onehot_s;
         if (match_count_r != {CNT_W{1'b1}}) match_count_r <= match_count_r + CNT_W'(1);
         else                                match_count_r <= match_count_r;
      end else begin
         match_count_r <= match_count_r;
         match_map_r   <= match_map_r;
      end
   end

   assign bus.det_clear   = det_clear_r;
   assign bus.input_0     = input_0_r;
   assign bus.input_1     = input_1_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.match_count = match_count_r;
   assign bus.match_map   = match_map_r;

endmodule

// File: doc/seq_stim_ctrl.md
Name: seq_stim_ctrl

Overview:
- Stimulus sequencer for the overlapping-sequence detector (top_seq).
- Replaces the manual input_0/input_1/clear probes: holds a loadable bit pattern and replays it into the detector as one-cycle input pulses at a fixed pacing.
- Samples the detector's Mealy output on each issued bit and reports match count plus per-bit match map.
- Sits between the VIO/host control and top_seq in the debug wrapper.

Parameters:
- PAT_W, 16: maximum pattern length in bits.
- LEN_W, 5: width of the length field; must hold PAT_W.
- GAP_CYCLES, 4: idle cycles between issued bits; legal range 1..255.
- CNT_W, 5: width of match_count; saturates at all-ones.

Ports:
- clk_100M, in, 1: single clock, rising edge.
- clear_n, in, 1: synchronous active-low reset.
- load, in, 1: latch pattern_in/len_in; accepted only when not busy.
- pattern_in, in, PAT_W: bit i is issued i-th, LSB first.
- len_in, in, LEN_W: number of bits to issue, 0..PAT_W; values above PAT_W are clamped to PAT_W.
- start, in, 1: begin a run; accepted only in IDLE.
- abort, in, 1: terminate a run.
- det_out, in, 1: detector Mealy output.
- det_clear, out, 1: clear pulse to the detector.
- input_0, out, 1: one-cycle pulse, "bit 0".
- input_1, out, 1: one-cycle pulse, "bit 1".
- busy, out, 1: run in progress.
- done, out, 1: one-cycle pulse when a run completes normally.
- match_count, out, CNT_W: detections in the last run.
- match_map, out, PAT_W: bit i set if det_out=1 on issue of bit i.

Behaviour:
- Reset (clear_n=0 at an edge):
  - state=IDLE.
  - All outputs 0, including match_count and match_map.
  - Stored pattern=0, stored len=0, bit index=0, gap timer=0.
- All registers update on the clk_100M rising edge; no combinational path from any input to any output.
- States are IDLE, CLR, ISSUE, GAP, DONE.
- IDLE:
  - load=1 latches pattern_in and len_in (len clamped).
  - start=1 moves to CLR. If load and start are asserted together, the run uses the newly presented values.
- CLR (1 cycle):
  - det_clear=1, busy=1.
  - match_count and match_map cleared; index=0.
  - Next state: ISSUE if len≠0, else DONE.
- ISSUE (1 cycle):
  - Drives input_1=pat[idx] and input_0=~pat[idx]; exactly one is high.
  - The same cycle samples det_out. If det_out=1: match_count+1 (saturating) and match_map[idx]=1.
  - Next state: GAP, with timer loaded to GAP_CYCLES.
- GAP (GAP_CYCLES cycles):
  - input_0 and input_1 are 0; det_out is ignored.
  - At timer expiry: idx+1. If idx+1==len, go to DONE; otherwise go to ISSUE.
- DONE (1 cycle):
  - done=1, busy=1.
  - Next state: IDLE, with busy=0 from then on.
- busy=1 in CLR, ISSUE, GAP and DONE; busy=0 only in IDLE.
- Issue period is GAP_CYCLES+1 cycles. Run latency from the start edge to done is 1 + len·(GAP_CYCLES+1) + 1 cycles.
- abort=1 in any busy state other than DONE:
  - Next cycle is CLR-like: det_clear=1 for one cycle, then IDLE.
  - No done pulse, no further input pulses.
  - match_count and match_map retain their partial values.
  - If abort and det_out coincide in ISSUE, the sample is still recorded.
- abort in DONE is ignored; done still fires.
- start, or load, while busy is ignored. A stored pattern is never changed mid-run.
- Reset asserted mid-run takes priority over everything: all outputs are 0 on the following cycle.
- match_count and match_map hold their values after DONE until the next CLR.

Decomposition:
- Shared package/header seq_ctrl_pkg:
  - State encoding constants ST_IDLE, ST_CLR, ST_ISSUE, ST_GAP, ST_DONE (3-bit).
  - Default GAP_CYCLES value.
- One sub-module, gap_timer:
  - Loadable 8-bit down-counter with a load pulse and an expire flag.
  - Instantiated once.
- All other logic stays in seq_stim_ctrl.

Test Plan:
- Reset: clear_n=0 for 2 cycles mid-run (during GAP) -> next cycle busy=0, done=0, det_clear=0, input_0=input_1=0, match_count=0, match_map=0.
- Basic replay: load pattern=0x000D, len=4, start at cycle 0, det_out=0, GAP_CYCLES=4 ->
  - det_clear at cycle 1.
  - input_1 at cycles 2, 12, 17; input_0 at cycle 7.
  - done at cycle 22; match_count=0.
- Detection sampling: same run, det_out=1 only on cycles 7 and 17, plus det_out=1 on GAP cycle 9 -> match_count=2, match_map=0x000A; the GAP-cycle assertion is ignored.
- Abort: same run, abort at cycle 14 (GAP after bit 2) -> det_clear at cycle 15, busy=0 at cycle 16, no pulse at cycle 17, no done; prior counts are retained.
- Edge lengths and ignored commands:
  - len=0 with start -> det_clear at cycle 1, done at cycle 2, no input pulses.
  - len=20 with PAT_W=16 -> exactly 16 pulses issued.
  - start during busy is ignored.
- Saturation: CNT_W=2, pattern=0xFFFF, len=8, det_out=1 on every issue -> match_count=3, match_map=0x00FF.
